// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register indices and data types.
package y86_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 15;

  typedef logic [3:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_RSP  = 4'h4;
  localparam reg_idx_t REG_NONE = 4'hF;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

endpackage

// File: rtl/y86_decode_regfile_if.sv
// Decode-stage bundle: fetch fields, write-back strobe and registered decode outputs.
interface y86_decode_regfile_if;
  import y86_pkg::*;

  logic       dec_valid;
  logic [3:0] icode;
  logic [3:0] ifun;
  reg_idx_t   rA;
  reg_idx_t   rB;

  logic       wb_en;
  reg_idx_t   wb_dstE;
  word_t      wb_valE;
  reg_idx_t   wb_dstM;
  word_t      wb_valM;

  logic       out_valid;
  logic [3:0] icode_q;
  logic [3:0] ifun_q;
  reg_idx_t   srcA;
  reg_idx_t   srcB;
  reg_idx_t   dstE;
  reg_idx_t   dstM;
  word_t      valA;
  word_t      valB;
  logic       err_illegal;

  modport master (
    output dec_valid, icode, ifun, rA, rB,
    output wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
    input  out_valid, icode_q, ifun_q, srcA, srcB, dstE, dstM, valA, valB, err_illegal
  );

  modport slave (
    input  dec_valid, icode, ifun, rA, rB,
    input  wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
    output out_valid, icode_q, ifun_q, srcA, srcB, dstE, dstM, valA, valB, err_illegal
  );

endinterface

// File: rtl/y86_regfile.sv
// 15x64 register file: two combinational read ports, two write ports (M beats E).
module y86_regfile
  import y86_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t rd_idx_a,
  output word_t    rd_data_a,
  input  reg_idx_t rd_idx_b,
  output word_t    rd_data_b,
  input  logic     wr_en,
  input  reg_idx_t wr_idx_e,
  input  word_t    wr_data_e,
  input  reg_idx_t wr_idx_m,
  input  word_t    wr_data_m
);

  word_t regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_idx_e != REG_NONE) regs_q[wr_idx_e] <= wr_data_e;
      // Later assignment wins, giving M priority when both ports hit one index.
      if (wr_idx_m != REG_NONE) regs_q[wr_idx_m] <= wr_data_m;
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_idx_a != REG_NONE) rd_data_a = regs_q[rd_idx_a];
    if (rd_idx_b != REG_NONE) rd_data_b = regs_q[rd_idx_b];
  end

endmodule

// File: rtl/y86_decode_regfile.sv
// SEQ decode/write-back stage: source/destination selection, register read with
// same-edge write-back bypass, and registered outputs toward execute.
module y86_decode_regfile
  import y86_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  y86_decode_regfile_if.slave bus
);

  reg_idx_t srca_d, srcb_d, dste_d, dstm_d;
  word_t    rf_a, rf_b, vala_d, valb_d;
  logic     illegal_d;

  logic       valid_q, err_q;
  logic [3:0] icode_q, ifun_q;
  reg_idx_t   srca_q, srcb_q, dste_q, dstm_q;
  word_t      vala_q, valb_q;

  always_comb begin
    srca_d    = REG_NONE;
    srcb_d    = REG_NONE;
    dste_d    = REG_NONE;
    dstm_d    = REG_NONE;
    illegal_d = (bus.icode > I_POP);
    case (bus.icode)
      I_CMOV:  begin srca_d = bus.rA;  dste_d = bus.rB; end
      I_IRMOV: begin dste_d = bus.rB; end
      I_RMMOV: begin srca_d = bus.rA;  srcb_d = bus.rB; end
      I_MRMOV: begin srcb_d = bus.rB;  dstm_d = bus.rA; end
      I_OPQ:   begin srca_d = bus.rA;  srcb_d = bus.rB; dste_d = bus.rB; end
      I_CALL:  begin srcb_d = REG_RSP; dste_d = REG_RSP; end
      I_RET:   begin srca_d = REG_RSP; srcb_d = REG_RSP; dste_d = REG_RSP; end
      I_PUSH:  begin srca_d = bus.rA;  srcb_d = REG_RSP; dste_d = REG_RSP; end
      I_POP:   begin
        srca_d = REG_RSP; srcb_d = REG_RSP; dste_d = REG_RSP; dstm_d = bus.rA;
      end
      default: ;
    endcase
  end

  y86_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_a  (srca_d),
    .rd_data_a (rf_a),
    .rd_idx_b  (srcb_d),
    .rd_data_b (rf_b),
    .wr_en     (bus.wb_en),
    .wr_idx_e  (bus.wb_dstE),
    .wr_data_e (bus.wb_valE),
    .wr_idx_m  (bus.wb_dstM),
    .wr_data_m (bus.wb_valM)
  );

  // Value being committed on this edge overrides the stored one; M checked first.
  function automatic word_t bypass(reg_idx_t src, word_t stored, logic en,
                                   reg_idx_t de, word_t ve, reg_idx_t dm, word_t vm);
    word_t v;
    v = stored;
    if (en && src != REG_NONE) begin
      if (dm == src)      v = vm;
      else if (de == src) v = ve;
    end
    return v;
  endfunction

  always_comb begin
    vala_d = bypass(srca_d, rf_a, bus.wb_en, bus.wb_dstE, bus.wb_valE,
                    bus.wb_dstM, bus.wb_valM);
    valb_d = bypass(srcb_d, rf_b, bus.wb_en, bus.wb_dstE, bus.wb_valE,
                    bus.wb_dstM, bus.wb_valM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      icode_q <= '0;
      ifun_q  <= '0;
      srca_q  <= REG_NONE;
      srcb_q  <= REG_NONE;
      dste_q  <= REG_NONE;
      dstm_q  <= REG_NONE;
      vala_q  <= '0;
      valb_q  <= '0;
    end else if (bus.dec_valid) begin
      valid_q <= 1'b1;
      err_q   <= illegal_d;
      icode_q <= bus.icode;
      ifun_q  <= bus.ifun;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.err_illegal = err_q;
  assign bus.icode_q     = icode_q;
  assign bus.ifun_q      = ifun_q;
  assign bus.srcA        = srca_q;
  assign bus.srcB        = srcb_q;
  assign bus.dstE        = dste_q;
  assign bus.dstM        = dstm_q;
  assign bus.valA        = vala_q;
  assign bus.valB        = valb_q;

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Directed bench for the decode/write-back stage with an expected-result scoreboard.
module tb_y86_decode_regfile;
  import y86_pkg::*;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vala;
    logic [63:0] valb;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb_q [$];
  exp_t last;

  y86_decode_regfile_if bus ();

  y86_decode_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic [3:0] ic, logic [3:0] fn, logic [3:0] sa, logic [3:0] sb,
                              logic [3:0] de, logic [3:0] dm, logic [63:0] va,
                              logic [63:0] vb, logic er);
    exp_t e;
    e = '{icode: ic, ifun: fn, srca: sa, srcb: sb, dste: de, dstm: dm,
          vala: va, valb: vb, err: er};
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    chk({tag, ".icode_q"}, 64'(bus.icode_q), 64'(e.icode));
    chk({tag, ".ifun_q"},  64'(bus.ifun_q),  64'(e.ifun));
    chk({tag, ".srcA"},    64'(bus.srcA),    64'(e.srca));
    chk({tag, ".srcB"},    64'(bus.srcB),    64'(e.srcb));
    chk({tag, ".dstE"},    64'(bus.dstE),    64'(e.dste));
    chk({tag, ".dstM"},    64'(bus.dstM),    64'(e.dstm));
    chk({tag, ".valA"},    bus.valA,         e.vala);
    chk({tag, ".valB"},    bus.valB,         e.valb);
    chk({tag, ".err"},     64'(bus.err_illegal), 64'(e.err));
  endtask

  task automatic set_wb(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
    bus.wb_en   = 1'b1;
    bus.wb_dstE = de;
    bus.wb_valE = ve;
    bus.wb_dstM = dm;
    bus.wb_valM = vm;
  endtask

  task automatic after_edge();
    @(negedge clk);
    bus.dec_valid = 1'b0;
    bus.wb_en     = 1'b0;
  endtask

  task automatic decode(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input exp_t e);
    exp_t got;
    bus.dec_valid = 1'b1;
    bus.icode     = ic;
    bus.ifun      = fn;
    bus.rA        = ra;
    bus.rB        = rb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 64'(sb_q.size()), 64'd1);
      end else begin
        got = sb_q.pop_front();
        check_fields(tag, got);
        last = got;
      end
    end
    after_edge();
  endtask

  task automatic idle(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    check_fields({tag, ".hold"}, last);
    after_edge();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    bus.dec_valid = 1'b0;
    bus.icode     = '0;
    bus.ifun      = '0;
    bus.rA        = '0;
    bus.rB        = '0;
    bus.wb_en     = 1'b0;
    bus.wb_dstE   = REG_NONE;
    bus.wb_valE   = '0;
    bus.wb_dstM   = REG_NONE;
    bus.wb_valM   = '0;
    rst_n         = 1'b0;
    #12;
    last = mk(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check_fields("reset", last);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: opq on an empty file, then an idle cycle holding outputs
    decode("opq", I_OPQ, 4'h1, 4'h6, 4'h7, mk(I_OPQ, 4'h1, 4'h6, 4'h7, 4'h7, 4'hF, 0, 0, 0));
    idle("opq_idle");

    // 2: write r3, then cmov reads it
    set_wb(4'h3, 64'h1234, REG_NONE, 64'hDEAD);
    idle("wb_r3");
    decode("cmov", I_CMOV, 4'h3, 4'h3, 4'h5,
           mk(I_CMOV, 4'h3, 4'h3, 4'hF, 4'h5, 4'hF, 64'h1234, 0, 0));

    // 3: same-edge M write bypasses into valA
    set_wb(REG_NONE, 64'h5555, 4'h6, 64'hAA);
    decode("rmmov_byp", I_RMMOV, 4'h0, 4'h6, 4'h7,
           mk(I_RMMOV, 4'h0, 4'h6, 4'h7, 4'hF, 4'hF, 64'hAA, 0, 0));

    // 4: E and M both target rsp; M wins in storage
    set_wb(4'h4, 64'h100, 4'h4, 64'h200);
    idle("wb_rsp");
    decode("ret", I_RET, 4'h0, 4'hF, 4'hF,
           mk(I_RET, 4'h0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h200, 64'h200, 0));

    // E/M collision on the decode edge: M wins in the bypass too
    set_wb(4'h4, 64'h111, 4'h4, 64'h222);
    decode("ret_byp", I_RET, 4'h0, 4'hF, 4'hF,
           mk(I_RET, 4'h0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h222, 64'h222, 0));

    // 5: popq with same-edge E bypass, then pushq
    set_wb(4'h4, 64'h300, REG_NONE, 64'h0);
    decode("popq", I_POP, 4'h0, 4'h1, 4'hF,
           mk(I_POP, 4'h0, 4'h4, 4'h4, 4'h4, 4'h1, 64'h300, 64'h300, 0));
    decode("pushq", I_PUSH, 4'h0, 4'h2, 4'hF,
           mk(I_PUSH, 4'h0, 4'h2, 4'h4, 4'h4, 4'hF, 64'h0, 64'h300, 0));
    decode("mrmov", I_MRMOV, 4'h0, 4'h3, 4'h7,
           mk(I_MRMOV, 4'h0, 4'hF, 4'h7, 4'hF, 4'h3, 64'h0, 64'h0, 0));
    decode("call", I_CALL, 4'h0, 4'hF, 4'hF,
           mk(I_CALL, 4'h0, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'h300, 0));
    decode("irmov", I_IRMOV, 4'h0, 4'hF, 4'h9,
           mk(I_IRMOV, 4'h0, 4'hF, 4'hF, 4'h9, 4'hF, 64'h0, 64'h0, 0));

    // 6: illegal icode, then a legal slot clears the flag and registers survived
    decode("illegal", 4'hC, 4'h5, 4'h3, 4'h3,
           mk(4'hC, 4'h5, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1));
    idle("illegal_idle");
    decode("cmov_after", I_CMOV, 4'h0, 4'h3, 4'hF,
           mk(I_CMOV, 4'h0, 4'h3, 4'hF, 4'hF, 4'hF, 64'h1234, 64'h0, 0));
    decode("halt", I_HALT, 4'h0, 4'h3, 4'h6,
           mk(I_HALT, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 0));

    // Mid-cycle reset discards an in-flight decode
    decode("opq_pre_rst", I_OPQ, 4'h0, 4'h3, 4'h6,
           mk(I_OPQ, 4'h0, 4'h3, 4'h6, 4'h6, 4'hF, 64'h1234, 64'hAA, 0));
    bus.dec_valid = 1'b1;
    bus.icode     = I_OPQ;
    bus.rA        = 4'h3;
    bus.rB        = 4'h6;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    last = mk(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    check_fields("midrst", last);
    after_edge();
    rst_n = 1'b1;
    @(negedge clk);
    decode("post_rst", I_OPQ, 4'h0, 4'h3, 4'h6,
           mk(I_OPQ, 4'h0, 4'h3, 4'h6, 4'h6, 4'hF, 64'h0, 64'h0, 0));
    decode("post_rst_rsp", I_RET, 4'h0, 4'hF, 4'hF,
           mk(I_RET, 4'h0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0, 0));

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
